// File: rtl/bitwise_pipe_op.sv
// Pipelined bitwise logic unit with run-time op select and valid/ready flow
// control on both sides. Each stage advances independently, so bubbles
// collapse while the consumer stalls.
module bitwise_pipe_op #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        op,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  y,
    output logic [$clog2(STAGES+1)-1:0]       occupancy
);

    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]            r_valid;
    logic [STAGES-1:0][WIDTH-1:0] r_data;

    logic [STAGES-1:0]            w_adv;
    logic [STAGES-1:0]            w_load;
    logic [STAGES-1:0][WIDTH-1:0] w_next;
    logic [WIDTH-1:0]             w_result;
    logic                         w_accept;
    logic [OCC_W-1:0]             w_occ;

    // Logic operation on the offered operands; only captured on acceptance.
    always_comb begin
        w_result = '0;
        unique case (op)
            2'd0: w_result = a & b;
            2'd1: w_result = a | b;
            2'd2: w_result = a ^ b;
            2'd3: w_result = a & ~b;
        endcase
    end

    // Advance chain, resolved from the output back towards the input so a
    // draining last stage lets every full stage behind it move up.
    always_comb begin
        w_adv = '0;
        w_adv[STAGES-1] = r_valid[STAGES-1] & out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            w_adv[k] = r_valid[k] & (~r_valid[k+1] | w_adv[k+1]);
        end
    end

    assign in_ready = ~r_valid[0] | w_adv[0];
    assign w_accept = in_valid & in_ready;

    // Per-stage load strobes and incoming data.
    always_comb begin
        w_load    = '0;
        w_next    = '0;
        w_load[0] = w_accept;
        w_next[0] = w_result;
        for (int k = 1; k < int'(STAGES); k++) begin
            w_load[k] = w_adv[k-1];
            w_next[k] = r_data[k-1];
        end
    end

    // Stage registers: valid follows load/drain, data only written on load
    // so the output holds steady while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_data  <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                r_valid[k] <= w_load[k] | (r_valid[k] & ~w_adv[k]);
                if (w_load[k]) begin
                    r_data[k] <= w_next[k];
                end
            end
        end
    end

    // Occupancy is the population count of the stage valid bits.
    always_comb begin
        w_occ = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            w_occ = w_occ + OCC_W'(r_valid[k]);
        end
    end

    assign occupancy = w_occ;
    assign out_valid = r_valid[STAGES-1];
    assign y         = r_data[STAGES-1];

endmodule

// File: tb/tb_bitwise_pipe_op.sv
// Directed and random checks of bitwise_pipe_op in three configurations:
// A = 8-bit/2-stage, B = 8-bit/3-stage, C = 32-bit/1-stage.
module tb_bitwise_pipe_op;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cnt = 0;
    always @(posedge clock) cnt <= cnt + 1;

    // DUT A
    logic       a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [1:0] a_op = 0, a_occ;
    logic [7:0] a_a = 0, a_b = 0, a_y;
    // DUT B
    logic       b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [1:0] b_op = 0, b_occ;
    logic [7:0] b_a = 0, b_b = 0, b_y;
    // DUT C
    logic        c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
    logic [1:0]  c_op = 0;
    logic        c_occ;
    logic [31:0] c_a = 0, c_b = 0, c_y;

    bitwise_pipe_op #(.WIDTH(8), .STAGES(2)) u_a (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(a_op), .a(a_a), .b(a_b), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .y(a_y), .occupancy(a_occ)
    );
    bitwise_pipe_op #(.WIDTH(8), .STAGES(3)) u_b (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .a(b_a), .b(b_b), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .y(b_y), .occupancy(b_occ)
    );
    bitwise_pipe_op #(.WIDTH(32), .STAGES(1)) u_c (
        .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .op(c_op), .a(c_a), .b(c_b), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .y(c_y), .occupancy(c_occ)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  q_a[$], q_b[$];
    logic [31:0] q_c[$];
    logic [7:0]  a_log[$], b_log[$];
    int          a_log_cyc[$];
    int          c_pops = 0;
    logic        a_acc, b_acc, c_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] x,
                                           input logic [31:0] z);
        case (op)
            2'd0:    return x & z;
            2'd1:    return x | z;
            2'd2:    return x ^ z;
            default: return x & ~z;
        endcase
    endfunction

    // One clock of DUT A with inputs already driven: check occupancy and
    // in_ready against the scoreboard depth, score the handshakes, advance.
    task automatic cyc_a();
        logic [7:0] e;
        #1;
        check("a_occ", 32'(a_occ), 32'(q_a.size()));
        check("a_in_ready", 32'(a_in_ready), 32'((q_a.size() < 2) || a_out_ready));
        a_acc = a_in_valid && a_in_ready;
        if (a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) check("a_spurious", 32'(a_out_valid), 32'd0);
            else begin
                e = q_a.pop_front();
                check("a_y", 32'(a_y), 32'(e));
                a_log.push_back(a_y);
                a_log_cyc.push_back(cnt);
            end
        end
        if (a_acc) q_a.push_back(8'(ref_op(a_op, 32'(a_a), 32'(a_b))));
        @(posedge clock);
        #1;
    endtask

    task automatic cyc_b();
        logic [7:0] e;
        #1;
        check("b_occ", 32'(b_occ), 32'(q_b.size()));
        check("b_in_ready", 32'(b_in_ready), 32'((q_b.size() < 3) || b_out_ready));
        b_acc = b_in_valid && b_in_ready;
        if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) check("b_spurious", 32'(b_out_valid), 32'd0);
            else begin
                e = q_b.pop_front();
                check("b_y", 32'(b_y), 32'(e));
                b_log.push_back(b_y);
            end
        end
        if (b_acc) q_b.push_back(8'(ref_op(b_op, 32'(b_a), 32'(b_b))));
        @(posedge clock);
        #1;
    endtask

    task automatic cyc_c();
        logic [31:0] e;
        #1;
        check("c_occ", 32'(c_occ), 32'(q_c.size()));
        check("c_in_ready", 32'(c_in_ready), 32'((q_c.size() < 1) || c_out_ready));
        c_acc = c_in_valid && c_in_ready;
        if (c_out_valid && c_out_ready) begin
            if (q_c.size() == 0) check("c_spurious", 32'(c_out_valid), 32'd0);
            else begin
                e = q_c.pop_front();
                check("c_y", c_y, e);
                c_pops++;
            end
        end
        if (c_acc) q_c.push_back(ref_op(c_op, c_a, c_b));
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] sweep_exp [4];
        int sent;
        bit pend;
        sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'hCC; sweep_exp[3] = 8'hC0;

        // Reset for 16 cycles, then check the idle state of every instance.
        repeat (16) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_a_ov", 32'(a_out_valid), 0);
        check("rst_a_y", 32'(a_y), 0);
        check("rst_a_occ", 32'(a_occ), 0);
        check("rst_a_ir", 32'(a_in_ready), 1);
        check("rst_b_occ", 32'(b_occ), 0);
        check("rst_b_ir", 32'(b_in_ready), 1);
        check("rst_c_ov", 32'(c_out_valid), 0);
        check("rst_c_ir", 32'(c_in_ready), 1);

        // Single beat latency on A: visible exactly 2 cycles after accept.
        a_out_ready = 1; a_in_valid = 1; a_a = 8'd3; a_b = 8'd3; a_op = 2'd0;
        cyc_a();
        a_in_valid = 0;
        check("lat_ov_t1", 32'(a_out_valid), 0);
        cyc_a();
        check("lat_ov_t2", 32'(a_out_valid), 1);
        check("lat_y", 32'(a_y), 32'd3);
        cyc_a();
        check("lat_ov_t3", 32'(a_out_valid), 0);

        // Op sweep, back to back, full throughput.
        a_log.delete(); a_log_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1; a_a = 8'hF0; a_b = 8'h3C; a_op = 2'(i);
            #1;
            check("sweep_ready", 32'(a_in_ready), 1);
            cyc_a();
        end
        a_in_valid = 0;
        repeat (3) cyc_a();
        check("sweep_count", 32'(a_log.size()), 4);
        if (a_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("sweep_y", 32'(a_log[i]), 32'(sweep_exp[i]));
            check("sweep_consec", 32'(a_log_cyc[3] - a_log_cyc[0]), 3);
        end

        // Backpressure on B: three beats fill it, the fourth is refused.
        b_out_ready = 0; b_log.delete();
        for (int i = 1; i <= 3; i++) begin
            b_in_valid = 1; b_a = 8'(i); b_b = 8'hFF; b_op = 2'd0;
            cyc_b();
        end
        b_a = 8'd4;
        #1;
        check("bp_ir", 32'(b_in_ready), 0);
        check("bp_occ", 32'(b_occ), 3);
        check("bp_ov", 32'(b_out_valid), 1);
        check("bp_y", 32'(b_y), 1);
        cyc_b();
        cyc_b();
        check("bp_y_hold", 32'(b_y), 1);
        b_out_ready = 1;
        b_acc = 0;
        for (int i = 0; i < 10 && !b_acc; i++) cyc_b();
        check("bp_4th_acc", 32'(b_acc), 1);
        b_in_valid = 0;
        for (int i = 0; i < 20 && q_b.size() > 0; i++) cyc_b();
        check("bp_drained", 32'(q_b.size()), 0);
        check("bp_occ_end", 32'(b_occ), 0);
        check("bp_count", 32'(b_log.size()), 4);
        if (b_log.size() == 4)
            for (int i = 0; i < 4; i++) check("bp_order", 32'(b_log[i]), 32'(i + 1));

        // Bubble collapse on B: second beat accepted during a stall.
        b_out_ready = 0; b_log.delete();
        b_in_valid = 1; b_a = 8'h55; b_b = 8'h0F; b_op = 2'd1;
        cyc_b();
        b_in_valid = 0;
        cyc_b();
        b_in_valid = 1; b_a = 8'hAA; b_b = 8'h0F; b_op = 2'd2;
        cyc_b();
        b_in_valid = 0;
        cyc_b();
        check("bub_occ", 32'(b_occ), 2);
        check("bub_ir", 32'(b_in_ready), 1);
        check("bub_ov", 32'(b_out_valid), 1);
        check("bub_y", 32'(b_y), 32'h5F);
        b_out_ready = 1;
        for (int i = 0; i < 20 && q_b.size() > 0; i++) cyc_b();
        check("bub_count", 32'(b_log.size()), 2);
        if (b_log.size() == 2) begin
            check("bub_first", 32'(b_log[0]), 32'h5F);
            check("bub_second", 32'(b_log[1]), 32'hA5);
        end

        // Reset in the middle of operation on A.
        a_out_ready = 0; a_log.delete();
        a_in_valid = 1; a_a = 8'h11; a_b = 8'h00; a_op = 2'd1;
        cyc_a();
        a_a = 8'h22;
        cyc_a();
        a_in_valid = 0;
        check("mid_occ", 32'(a_occ), 2);
        check("mid_ov", 32'(a_out_valid), 1);
        reset = 1; a_out_ready = 1; a_in_valid = 1; a_a = 8'h33;
        @(posedge clock);
        #1;
        reset = 0; a_in_valid = 0;
        q_a.delete();
        check("mid_rst_ov", 32'(a_out_valid), 0);
        check("mid_rst_y", 32'(a_y), 0);
        check("mid_rst_occ", 32'(a_occ), 0);
        check("mid_rst_ir", 32'(a_in_ready), 1);
        repeat (5) cyc_a();
        check("mid_no_stale", 32'(a_log.size()), 0);
        a_in_valid = 1; a_a = 8'h44; a_b = 8'h00; a_op = 2'd1;
        cyc_a();
        a_in_valid = 0;
        for (int i = 0; i < 10 && q_a.size() > 0; i++) cyc_a();
        check("mid_after_count", 32'(a_log.size()), 1);
        if (a_log.size() == 1) check("mid_after_y", 32'(a_log[0]), 32'h44);

        // Random traffic on C; the producer holds an offered beat until taken.
        sent = 0; pend = 0;
        for (int cy = 0; cy < 20000 && sent < 1000; cy++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                c_a = $urandom; c_b = $urandom; c_op = 2'($urandom_range(0, 3));
                pend = 1;
            end
            c_in_valid  = pend;
            c_out_ready = 1'($urandom_range(0, 1));
            cyc_c();
            if (c_acc) begin
                pend = 0;
                sent++;
            end
        end
        c_in_valid = 0; c_out_ready = 1;
        for (int i = 0; i < 10 && q_c.size() > 0; i++) cyc_c();
        check("rand_sent", 32'(sent), 1000);
        check("rand_pops", 32'(c_pops), 1000);
        check("rand_empty", 32'(q_c.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
